// File: rtl/tetris_input_pkg.sv
// -----------------------------------------------------------------------------
// tetris_input_pkg
// Shared types and default timing for the pushbutton conditioning stage.
//   rep_state_t      : per-button command FSM state (IDLE / DELAY / REPEAT).
//                      A non-repeating button uses DELAY as its "held" state.
//   DEF_*_CYCLES     : default timing at a 50 MHz clock.
//   max2()           : helper used to size the shared repeat counter.
// -----------------------------------------------------------------------------
package tetris_input_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam int DEF_DEBOUNCE_CYCLES  = 500000;   // 10 ms
    localparam int DEF_DAS_DELAY_CYCLES = 8000000;  // 160 ms
    localparam int DEF_ARR_CYCLES       = 2500000;  // 50 ms

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tetris_input_ctrl_button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// One pushbutton: 2-flop synchronizer, counting debouncer, rise detector and
// a command FSM that requests a single-cycle pulse on each press and, when
// REPEAT_EN is set, delayed auto-repeat while held.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   run        : low holds the FSM in IDLE and suppresses requests
//   raw        : asynchronous active-high button level
//   req        : combinational pulse request (registered by the parent)
// Handshake: req is a plain one-cycle strobe; there is no back-pressure.
// -----------------------------------------------------------------------------
module button_conditioner
    import tetris_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int DAS_DELAY_CYCLES = DEF_DAS_DELAY_CYCLES,
    parameter int ARR_CYCLES       = DEF_ARR_CYCLES,
    parameter bit REPEAT_EN        = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic raw,
    output logic req
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = $clog2(max2(DAS_DELAY_CYCLES, ARR_CYCLES)) + 1;

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DAS_LAST = CW'(DAS_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] ARR_LAST = CW'(ARR_CYCLES - 1);

    logic          sync_meta;
    logic          sync_q;
    logic          deb;
    logic          deb_q;
    logic [DW-1:0] deb_cnt;
    logic          rise;

    rep_state_t    state;
    rep_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Synchronizer and debouncer. The debouncer keeps running regardless of
    // run so that a button already held when run rises is seen as held, not
    // as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            deb       <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
            deb_q     <= deb;
            if (sync_q == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= ~deb;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    assign rise = deb & ~deb_q;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // FSM next state. A debounced fall returns to IDLE from any state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!run) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_next = DELAY;
                        cnt_next   = '0;
                    end
                end
                DELAY: begin
                    if (!deb) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (REPEAT_EN) begin
                        if (cnt == DAS_LAST) begin
                            state_next = REPEAT;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + CW'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (!deb) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == ARR_LAST) begin
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // FSM output: one request per press event and per repeat interval
    always_comb begin
        req = 1'b0;
        if (run) begin
            case (state)
                IDLE:    req = rise;
                DELAY:   req = REPEAT_EN && deb && (cnt == DAS_LAST);
                REPEAT:  req = REPEAT_EN && deb && (cnt == ARR_LAST);
                default: req = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// -----------------------------------------------------------------------------
// tetris_input_ctrl
// Turns raw left/right/rotate pushbutton levels into single-cycle command
// pulses for the game core. Left/right auto-repeat while held; rotate fires
// once per press.
// Ports:
//   clk        : system clock (50 MHz)
//   reset      : asynchronous active-high reset
//   run        : game-running enable; low forces all outputs to 0
//   left_raw, right_raw, rotate_raw : asynchronous active-high button levels
//   left, right, rotate             : registered one-cycle command pulses
// -----------------------------------------------------------------------------
module tetris_input_ctrl
    import tetris_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int DAS_DELAY_CYCLES = DEF_DAS_DELAY_CYCLES,
    parameter int ARR_CYCLES       = DEF_ARR_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic left_raw,
    input  logic right_raw,
    input  logic rotate_raw,
    output logic left,
    output logic right,
    output logic rotate
);

    logic left_req;
    logic right_req;
    logic rotate_req;

    button_conditioner #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .DAS_DELAY_CYCLES (DAS_DELAY_CYCLES),
        .ARR_CYCLES       (ARR_CYCLES),
        .REPEAT_EN        (1'b1)
    ) u_left (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .raw   (left_raw),
        .req   (left_req)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .DAS_DELAY_CYCLES (DAS_DELAY_CYCLES),
        .ARR_CYCLES       (ARR_CYCLES),
        .REPEAT_EN        (1'b1)
    ) u_right (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .raw   (right_raw),
        .req   (right_req)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .DAS_DELAY_CYCLES (DAS_DELAY_CYCLES),
        .ARR_CYCLES       (ARR_CYCLES),
        .REPEAT_EN        (1'b0)
    ) u_rotate (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .raw   (rotate_raw),
        .req   (rotate_req)
    );

    // Opposing moves in the same cycle cancel; the FSMs keep their timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left   <= 1'b0;
            right  <= 1'b0;
            rotate <= 1'b0;
        end else begin
            left   <= run & left_req & ~right_req;
            right  <= run & right_req & ~left_req;
            rotate <= run & rotate_req;
        end
    end

endmodule
